// File: rtl/hilo_pkg.sv
// hilo_pkg: definitions shared by the HI/LO register unit and its watchdog.
//   - parameter defaults for data width, timeout limit and counter width
//   - hilo_state_e: tracks which unit, if any, owes the HI/LO pair a result
package hilo_pkg;

  localparam int unsigned WIDTH_DEF          = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 40;
  localparam int unsigned CNT_W_DEF          = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_WAIT = 2'd1,
    DIV_WAIT  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/op_watchdog.sv
// op_watchdog: cycle counter that watches an outstanding operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart counting from zero (a new operation was issued)
//   en         : one more cycle passed without the operation completing
//   count      : current count
//   tc         : terminal count, combinational; high while en is high and
//                count has reached LIMIT-1, so this cycle exhausts the budget
module op_watchdog #(
  parameter int unsigned LIMIT = 40,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      // Wrap at the terminal count so the next operation starts from zero
      // even if it is issued without an explicit clear.
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair fed by the multiplier and
// the divider, serving MFHI/MFLO reads and MTHI/MTLO writes.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mult_start, div_start : operation issued this cycle (div wins if both)
//   mult_done/hi/lo       : multiplier result
//   div_done/quot/rem     : divider result, div_by_zero qualifies it
//   mthi, mtlo, wdata     : writes to HI/LO (both may be written together)
//   mfhi, mflo            : read requests (HI wins if both)
//   rdata, rdata_valid    : registered read data, one cycle after request
//   stall                 : request blocked because an op is outstanding
//   hi, lo                : current register contents
//   busy                  : an operation is outstanding
//   div_zero_flag         : last captured divide had a zero divisor
//   timeout               : one-cycle pulse, outstanding op abandoned
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_by_zero,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_zero_flag,
  output logic             timeout
);

  hilo_state_e      state_q, state_d;
  logic             start_any;
  logic             done_match;
  logic             capture_mult;
  logic             capture_div;
  logic             expire;
  logic             wd_en;
  logic             wd_tc;
  logic [CNT_W-1:0] wd_count;
  logic             rd_req;
  logic             rd_ok;

  assign busy      = (state_q != IDLE);
  assign start_any = mult_start | div_start;
  assign rd_req    = mfhi | mflo;
  assign rd_ok     = rd_req & ~busy;
  // Depends only on registered state and inputs, never on rdata/hi/lo.
  assign stall     = (rd_req | mthi | mtlo) & busy;

  assign done_match = ((state_q == MULT_WAIT) & mult_done) |
                      ((state_q == DIV_WAIT)  & div_done);

  // The watchdog only ages a wait that neither restarts nor completes.
  assign wd_en = busy & ~start_any & ~done_match;

  op_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_any),
    .en    (wd_en),
    .count (wd_count),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A start overrides everything, including a result arriving in the same
  // cycle; done and timeout are only considered in the matching wait state.
  always_comb begin
    state_d      = state_q;
    capture_mult = 1'b0;
    capture_div  = 1'b0;
    expire       = 1'b0;
    if (div_start) begin
      state_d = DIV_WAIT;
    end else if (mult_start) begin
      state_d = MULT_WAIT;
    end else begin
      unique case (state_q)
        MULT_WAIT: begin
          if (mult_done) begin
            capture_mult = 1'b1;
            state_d      = IDLE;
          end else if (wd_tc) begin
            expire  = 1'b1;
            state_d = IDLE;
          end
        end
        DIV_WAIT: begin
          if (div_done) begin
            capture_div = 1'b1;
            state_d     = IDLE;
          end else if (wd_tc) begin
            expire  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Captures happen only while busy and writes only while idle, so the two
  // never compete for HI/LO in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi            <= '0;
      lo            <= '0;
      div_zero_flag <= 1'b0;
    end else if (capture_mult) begin
      hi <= mult_hi;
      lo <= mult_lo;
    end else if (capture_div) begin
      hi            <= div_rem;
      lo            <= div_quot;
      div_zero_flag <= div_by_zero;
    end else if (!busy) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

  // Reads sample the pre-edge HI/LO, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rdata_valid <= rd_ok;
      timeout     <= expire;
      if (rd_ok) rdata <= mfhi ? hi : lo;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mult_start, div_start, mult_done, div_done, div_by_zero;
  logic [W-1:0] mult_hi, mult_lo, div_quot, div_rem, wdata;
  logic         mthi, mtlo, mfhi, mflo;
  logic [W-1:0] rdata, hi, lo;
  logic         rdata_valid, stall, busy, div_zero_flag, timeout;

  hilo_unit #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .mult_start(mult_start), .div_start(div_start),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .div_by_zero(div_by_zero),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall),
    .hi(hi), .lo(lo), .busy(busy), .div_zero_flag(div_zero_flag),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: which unit owes a result, how long it has been owed.
  int           m_pend;   // 0 none, 1 multiply, 2 divide
  int unsigned  m_age;
  logic [W-1:0] m_hi, m_lo;
  bit           m_flag, m_to;
  logic [W-1:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mult_start = 0; div_start = 0; mult_done = 0; div_done = 0; div_by_zero = 0;
    mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
    mult_hi = '0; mult_lo = '0; div_quot = '0; div_rem = '0; wdata = '0;
  endtask

  task automatic model_reset();
    m_pend = 0; m_age = 0; m_hi = '0; m_lo = '0; m_flag = 0; m_to = 0;
    exp_q.delete();
  endtask

  // Inputs are already driven (posedge+1). Check at +3, advance on the edge.
  task automatic step();
    bit           was_busy, rd;
    logic [W-1:0] rd_val;
    #2;
    was_busy = (m_pend != 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("busy", busy, was_busy);
    check("div_zero_flag", div_zero_flag, m_flag);
    check("timeout", timeout, m_to);
    check("stall", stall, (mfhi | mflo | mthi | mtlo) & was_busy);
    rd     = (mfhi | mflo) & !was_busy;
    rd_val = mfhi ? m_hi : m_lo;
    m_to = 0;
    if (div_start) begin
      m_pend = 2; m_age = 0;
    end else if (mult_start) begin
      m_pend = 1; m_age = 0;
    end else if (m_pend == 1 && mult_done) begin
      m_hi = mult_hi; m_lo = mult_lo; m_pend = 0;
    end else if (m_pend == 2 && div_done) begin
      m_hi = div_rem; m_lo = div_quot; m_flag = div_by_zero; m_pend = 0;
    end else if (m_pend != 0) begin
      m_age++;
      if (m_age == TO) begin m_pend = 0; m_to = 1; end
    end
    if (!was_busy) begin
      if (mthi) m_hi = wdata;
      if (mtlo) m_lo = wdata;
    end
    @(posedge clk);
    if (rd) exp_q.push_back(rd_val);
    #1;
  endtask

  // Monitor: every accepted read must return exactly one cycle later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rdata_valid: got unexpected pulse rdata=%0h expected none", rdata);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        tests++; fails++;
        $display("FAIL rdata_valid: got 0 expected 1 (pending %0d)", exp_q.size());
        exp_q.delete();
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_flag", div_zero_flag, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Read after reset
    mfhi = 1; step(); idle_inputs(); step();

    // Multiply with reads stalled during the wait
    mult_start = 1; step(); idle_inputs();
    mflo = 1; step(); step();
    mult_done = 1; mult_hi = 32'h0000_0001; mult_lo = 32'hFFFF_FFFE; step();
    idle_inputs(); mflo = 1; step(); idle_inputs(); step();

    // Divides, without and with zero divisor
    for (int k = 0; k < 2; k++) begin
      div_start = 1; step(); idle_inputs();
      div_done = 1; div_quot = 7; div_rem = 3; div_by_zero = 1'(k); step();
      idle_inputs(); step();
    end

    // Superseded multiply
    mult_start = 1; step(); idle_inputs(); step();
    div_start = 1; step(); idle_inputs();
    mult_done = 1; mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222; step();
    idle_inputs(); div_done = 1; div_quot = 5; div_rem = 1; step();
    idle_inputs(); mfhi = 1; mflo = 1; step(); idle_inputs(); step();

    // Timeout
    mult_start = 1; step(); idle_inputs();
    for (int i = 0; i < TO + 4; i++) step();

    // Write with same-cycle read, then read back
    mthi = 1; wdata = 32'hDEAD_BEEF; mfhi = 1; step();
    idle_inputs(); mfhi = 1; step(); idle_inputs(); step();

    // Asynchronous reset during a multiply wait
    mult_start = 1; step(); idle_inputs(); step();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_async_busy", busy, 0);
    check("rst_async_hi", hi, 0);
    check("rst_async_lo", lo, 0);
    @(posedge clk); #1;
    rst_n = 1;
    mult_done = 1; mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555; step();
    idle_inputs(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mult_start  = ($urandom % 20) == 0;
      div_start   = ($urandom % 20) == 0;
      mult_done   = ($urandom % 8) == 0;
      div_done    = ($urandom % 8) == 0;
      div_by_zero = ($urandom % 4) == 0;
      mult_hi = $urandom; mult_lo = $urandom;
      div_quot = $urandom; div_rem = $urandom;
      mthi = ($urandom % 6) == 0;
      mtlo = ($urandom % 6) == 0;
      mfhi = ($urandom % 4) == 0;
      mflo = ($urandom % 4) == 0;
      wdata = $urandom;
      step();
    end
    idle_inputs();
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
